// File: rtl/mac_sequencer.sv
// Control sequencer for a pipelined MAC: buffers samples in a circular delay line,
// streams (sample, coefficient) pairs with a first-tap load strobe, and captures the dot product.
module mac_sequencer #(
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 40,
  parameter int TAPS      = 8,
  parameter int ADDR_W    = 3,
  parameter int MAC_LAT   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH_IN-1:0]  in_data,
  output logic                 in_ready,
  input  logic                 coef_wr,
  input  logic [ADDR_W-1:0]    coef_addr,
  input  logic [WIDTH_IN-1:0]  coef_data,
  output logic                 busy,
  output logic [WIDTH_IN-1:0]  mac_dataa,
  output logic [WIDTH_IN-1:0]  mac_datab,
  output logic                 mac_sload,
  input  logic [WIDTH_OUT-1:0] mac_result,
  output logic                 out_valid,
  output logic [WIDTH_OUT-1:0] out_data
);

  localparam int CW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   wr_ptr, base, k, k_n, rd_idx;
  logic [CW-1:0]       drain_cnt;
  logic [WIDTH_IN-1:0] line [TAPS];
  logic [WIDTH_IN-1:0] coef [TAPS];
  logic                accept, last_tap, last_drain;

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = in_valid && in_ready;
  assign last_tap   = (k == ADDR_W'(TAPS - 1));
  assign last_drain = (drain_cnt == CW'(MAC_LAT - 1));

  always_comb begin
    state_n = state;
    k_n     = k + 1'b1;
    rd_idx  = base - k_n;
    unique case (state)
      IDLE:    if (accept)     state_n = MAC;
      MAC:     if (last_tap)   state_n = DRAIN;
      DRAIN:   if (last_drain) state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Operands are registered one tap ahead: tap 0 is loaded on the accept edge, bypassing
  // the delay-line write that happens on that same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      base      <= '0;
      k         <= '0;
      drain_cnt <= '0;
      mac_dataa <= '0;
      mac_datab <= '0;
      mac_sload <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        line[i] <= '0;
        coef[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            line[wr_ptr] <= in_data;
            base         <= wr_ptr;
            wr_ptr       <= wr_ptr + 1'b1;
            k            <= '0;
            mac_dataa    <= in_data;
            mac_datab    <= coef[0];
            mac_sload    <= 1'b1;
          end else if (coef_wr) begin
            coef[coef_addr] <= coef_data;
          end
        end
        MAC: begin
          mac_sload <= 1'b0;
          if (last_tap) begin
            mac_dataa <= '0;
            mac_datab <= '0;
            drain_cnt <= '0;
          end else begin
            k         <= k_n;
            mac_dataa <= line[rd_idx];
            mac_datab <= coef[k_n];
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (last_drain) begin
            out_data  <= mac_result;
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer (TAPS = 4) against a 3-stage MAC model with directed vectors.
module tb_mac_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [15:0]        in_data;
  logic               in_ready;
  logic               coef_wr;
  logic [1:0]         coef_addr;
  logic [15:0]        coef_data;
  logic               busy;
  logic [15:0]        mac_dataa, mac_datab;
  logic               mac_sload;
  logic [39:0]        mac_result;
  logic               out_valid;
  logic [39:0]        out_data;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int sload_total = 0;

  typedef struct {
    logic signed [15:0] x;
    int                 y;
  } vec_t;

  vec_t vec_a [11];
  vec_t vec_b [6];

  mac_sequencer #(
    .WIDTH_IN (16),
    .WIDTH_OUT(40),
    .TAPS     (4),
    .ADDR_W   (2),
    .MAC_LAT  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .coef_wr   (coef_wr),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (busy),
    .mac_dataa (mac_dataa),
    .mac_datab (mac_datab),
    .mac_sload (mac_sload),
    .mac_result(mac_result),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // MAC model: operands in cycle c -> accumulator visible in cycle c+3
  logic signed [15:0] s1a, s1b;
  logic               s1l, s2l;
  logic signed [31:0] s2p;
  logic signed [39:0] acc;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mac_sload) sload_total <= sload_total + 1;
    if (rst) begin
      s1a <= '0; s1b <= '0; s1l <= 1'b0;
      s2p <= '0; s2l <= 1'b0; acc <= '0;
    end else begin
      s1a <= mac_dataa;
      s1b <= mac_datab;
      s1l <= mac_sload;
      s2p <= s1a * s1b;
      s2l <= s1l;
      acc <= s2l ? 40'(s2p) : acc + 40'(s2p);
    end
  end
  assign mac_result = acc;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic load_coef(input logic [1:0] a, input logic signed [15:0] d);
    coef_wr = 1'b1; coef_addr = a; coef_data = d;
    @(posedge clk); #1;
    coef_wr = 1'b0;
  endtask

  // Accept one sample, optionally pulse a coefficient write in cycle T+wr_i, and check the result.
  task automatic send_sample(input logic signed [15:0] d, input int exp, input string nm,
                             input int wr_i, input logic [1:0] wa, input logic signed [15:0] wd);
    int  s0;
    bit  seen;
    for (int i = 0; i < 30 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    chk({nm, " in_ready"}, longint'(in_ready), 1);
    in_valid = 1'b1; in_data = d; s0 = sload_total;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      coef_wr = (i == wr_i); coef_addr = wa; coef_data = wd;
      if (out_valid) begin
        seen = 1'b1;
        chk({nm, " out_data"}, longint'($signed(out_data)), longint'(exp));
        chk({nm, " latency"}, longint'(i), 8);
      end else begin
        @(posedge clk); #1;
      end
    end
    coef_wr = 1'b0;
    chk({nm, " out_valid seen"}, longint'(seen), 1);
    @(posedge clk); #1;
    chk({nm, " pulse width"}, longint'(out_valid), 0);
    chk({nm, " sload count"}, longint'(sload_total - s0), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  nacc, nout, notready, last_acc;
    bit  saw;
    logic signed [15:0] bp_x [3];
    int  bp_y [3];

    vec_a = '{'{16'sd100, 100}, '{16'sd0, 200}, '{16'sd0, 300}, '{16'sd0, 400},
              '{16'sd0, 0},     '{16'sd10, 10}, '{16'sd10, 30}, '{16'sd10, 60},
              '{16'sd10, 100},  '{16'sd10, 100}, '{16'sd10, 100}};
    vec_b = '{'{16'sh8000, 32768}, '{16'sd1, -65537}, '{16'sd0, 98306},
              '{16'sd0, -1073709059}, '{16'sd0, 32767}, '{16'sd0, 0}};
    bp_x = '{16'sd7, 16'sd8, 16'sd9};
    bp_y = '{-7, 6, -14};

    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset in_ready",  longint'(in_ready), 1);
    chk("reset busy",      longint'(busy), 0);
    chk("reset mac_dataa", longint'(mac_dataa), 0);
    chk("reset mac_datab", longint'(mac_datab), 0);
    chk("reset mac_sload", longint'(mac_sload), 0);
    chk("reset out_valid", longint'(out_valid), 0);
    chk("reset out_data",  longint'(out_data), 0);

    // impulse then step, coefficients {1,2,3,4}
    for (int unsigned a = 0; a < 4; a++) load_coef(2'(a), 16'(a + 1));
    for (int i = 0; i < 11; i++)
      send_sample(vec_a[i].x, vec_a[i].y, $sformatf("vec_a[%0d]", i), 0, 2'd0, 16'sd0);

    // negative values and delay-line wrap, from a clean reset
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    load_coef(2'd0, -16'sd1);
    load_coef(2'd1, 16'sd2);
    load_coef(2'd2, -16'sd3);
    load_coef(2'd3, 16'sd32767);
    for (int i = 0; i < 6; i++)
      send_sample(vec_b[i].x, vec_b[i].y, $sformatf("vec_b[%0d]", i), 0, 2'd0, 16'sd0);

    // back-pressure: in_valid held high across three samples
    nacc = 0; nout = 0; notready = 0; last_acc = 0;
    for (int c = 0; c < 60 && nout < 3; c++) begin
      if (out_valid) begin
        chk($sformatf("bp out_data[%0d]", nout), longint'($signed(out_data)), longint'(bp_y[nout]));
        nout++;
      end
      if (nacc < 3) begin
        in_valid = 1'b1; in_data = bp_x[nacc];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        if (nacc > 0) begin
          chk("bp accept spacing", longint'(cyc - last_acc), 8);
          chk("bp not-ready cycles", longint'(notready), 7);
        end
        last_acc = cyc; notready = 0; nacc++;
      end else if (in_valid) begin
        notready++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp accepts", longint'(nacc), 3);
    chk("bp outputs", longint'(nout), 3);

    // coefficient writes: dropped while busy (MAC and last DRAIN cycle), applied in IDLE
    send_sample(16'sd1, 229362, "wr_busy", 2, 2'd0, 16'sd99);
    load_coef(2'd0, 16'sd99);
    send_sample(16'sd4, 262507, "wr_idle", 7, 2'd1, 16'sd55);
    send_sample(16'sd0, 294908, "wr_drain", 0, 2'd0, 16'sd0);

    // reset mid-MAC
    in_valid = 1'b1; in_data = 16'sd7;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort in_ready",  longint'(in_ready), 1);
    chk("abort busy",      longint'(busy), 0);
    chk("abort mac_dataa", longint'(mac_dataa), 0);
    chk("abort out_data",  longint'(out_data), 0);
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) saw = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort no out_valid", longint'(saw), 0);
    send_sample(16'sd5, 0, "post_abort", 0, 2'd0, 16'sd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
